mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/address width.
REQ-002 SHALL have parameter MEM_LATENCY, default 2, cycles a memory command is held before data is valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  1  instruction-fetch read request.
REQ-006 SHALL have port i_addr  input  WORD_SIZE  fetch address.
REQ-007 SHALL have port i_data  output  WORD_SIZE  fetched instruction.
REQ-008 SHALL have port i_ready  output  1  fetch-complete pulse.
REQ-009 SHALL have port d_read  input  1  data read request.
REQ-010 SHALL have port d_write  input  1  data write request.
REQ-011 SHALL have port d_addr  input  WORD_SIZE  data address.
REQ-012 SHALL have port d_wdata  input  WORD_SIZE  store data.
REQ-013 SHALL have port d_rdata  output  WORD_SIZE  load data.
REQ-014 SHALL have port d_ready  output  1  data-access-complete pulse.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  single-port memory commands.
REQ-016 SHALL have ports mem_addr, mem_wdata  output  WORD_SIZE each  memory address, write data.
REQ-017 SHALL have port mem_rdata  input  WORD_SIZE  memory read data, valid in last held cycle.
REQ-018 SHALL have ports i_count, d_count  output  WORD_SIZE each  completed-access counters.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_I, BUSY_D plus a latency down-counter.
REQ-020 SHALL treat a data request as pending when d_read or d_write is high; an instruction request as pending when i_req is high.
REQ-021 SHALL, in IDLE with any pending request, grant at the next rising edge: data over instruction (fixed priority, older pipeline stage first).
REQ-022 SHALL on grant latch address, direction and write data into internal registers and load counter with MEM_LATENCY-1.
REQ-023 SHALL drive mem_* only from the latched registers while BUSY; mem_read=mem_write=0, mem_addr=mem_wdata=0 in IDLE.
REQ-024 SHALL treat d_read and d_write both high as a write.
REQ-025 SHALL decrement the counter each BUSY cycle; the cycle with counter 0 is the final cycle.
REQ-026 SHALL in the final cycle assert i_ready (BUSY_I) or d_ready (BUSY_D) for exactly one cycle; for reads present mem_rdata on i_data/d_rdata that cycle and hold it in a register until the next completion.
REQ-027 SHALL, from a final cycle, go directly to the next BUSY state if any request is pending (priority per REQ-021, excluding the requester just completed unless it is the only one pending), otherwise to IDLE; no bubble between back-to-back accesses.
REQ-028 SHALL give request-to-ready latency of MEM_LATENCY cycles after grant (MEM_LATENCY+1 edges from request in IDLE).
REQ-029 SHALL ignore changes to requester inputs while BUSY; a request deasserted mid-access still completes and pulses ready.
REQ-030 SHALL increment i_count/d_count on each i_ready/d_ready pulse, wrapping from 2^WORD_SIZE-1 to 0.
REQ-031 SHALL never assert i_ready and d_ready in the same cycle, nor mem_read and mem_write together.

Reset
REQ-032 SHALL on reset_n low immediately force state IDLE, counter 0, all mem_* outputs 0, i_ready=d_ready=0, i_data=d_rdata=0, i_count=d_count=0, including mid-access; the aborted access is not counted.
REQ-033 SHALL grant no request on the first rising edge at which reset_n is already high after release only if sampled low; normal arbitration from the first edge with reset_n high.

Verification
REQ-034 SHALL cover: i_req, i_addr=0x0010, mem_rdata=0xA123, MEM_LATENCY=2 -> mem_read high 2 cycles at 0x0010, i_ready one pulse, i_data=0xA123, i_count=1.
REQ-035 SHALL cover: i_req and d_read same cycle -> BUSY_D first, d_ready pulse, then BUSY_I with no idle cycle, i_ready pulse.
REQ-036 SHALL cover: d_write, d_addr=0x0040, d_wdata=0x5555 -> mem_write high MEM_LATENCY cycles, mem_read 0, d_ready pulse, d_count=1.
REQ-037 SHALL cover: reset_n low during BUSY_D -> mem_* 0 asynchronously, counters 0, no ready pulse; post-reset i_req serviced normally.
REQ-038 SHALL cover: MEM_LATENCY=1 continuous i_req -> i_ready every cycle after first grant.
REQ-039 SHALL cover: d_count preset by 0xFFFF completions -> next completion wraps to 0x0000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by an instruction-fetch port and a
// load/store port. Data accesses win over fetches; each access holds the
// memory command for MEM_LATENCY cycles and pulses the requester's ready
// in the last cycle. Back-to-back accesses chain without an idle cycle.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] i_count,
  output logic [WORD_SIZE-1:0] d_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  // Counter value loaded on grant; the access ends when it reaches zero.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [WORD_SIZE-1:0] i_data_q, i_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic [WORD_SIZE-1:0] i_count_q, i_count_d;
  logic [WORD_SIZE-1:0] d_count_q, d_count_d;

  logic d_pend, busy, last, grant_i, grant_d, i_done, d_done;

  // Arbitration, grant latching and latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    d_pend  = d_read | d_write;
    busy    = (state_q != IDLE);
    last    = busy && (cnt_q == 4'd0);
    i_done  = last && (state_q == BUSY_I);
    d_done  = last && (state_q == BUSY_D);

    case (state_q)
      IDLE: begin
        grant_d = d_pend;
        grant_i = !d_pend && i_req;
      end
      BUSY_I: begin
        if (last) begin
          // Fetch just finished: data goes next if it is waiting.
          grant_d = d_pend;
          grant_i = !d_pend && i_req;
          if (!d_pend && !i_req) state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BUSY_D: begin
        if (last) begin
          // Data just finished: a waiting fetch gets its turn so it cannot starve.
          grant_i = i_req;
          grant_d = !i_req && d_pend;
          if (!i_req && !d_pend) state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_d) begin
      state_d = BUSY_D;
      addr_d  = d_addr;
      wdata_d = d_wdata;
      wr_d    = d_write;
      cnt_d   = LAT_LOAD;
    end else if (grant_i) begin
      state_d = BUSY_I;
      addr_d  = i_addr;
      wdata_d = '0;
      wr_d    = 1'b0;
      cnt_d   = LAT_LOAD;
    end
  end

  // Completion bookkeeping: capture read data and bump access counters.
  always_comb begin
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_count_d = i_count_q;
    d_count_d = d_count_q;
    if (i_done) begin
      i_data_d  = mem_rdata;
      i_count_d = i_count_q + WORD_SIZE'(1);
    end
    if (d_done) begin
      d_count_d = d_count_q + WORD_SIZE'(1);
      if (!wr_q) d_rdata_d = mem_rdata;
    end
  end

  // State and data registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_count_q <= '0;
      d_count_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_count_q <= i_count_d;
      d_count_q <= d_count_d;
    end
  end

  // Memory commands come only from the latched access; quiet when idle.
  assign mem_read  = busy && !wr_q;
  assign mem_write = busy && wr_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  // Read data is passed through in the completing cycle, then held.
  assign i_ready = i_done;
  assign d_ready = d_done;
  assign i_data  = i_data_d;
  assign d_rdata = d_rdata_d;
  assign i_count = i_count_q;
  assign d_count = d_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 16-bit, latency-2 instance driven
// through fetch/load/store/reset scenarios, plus a narrow latency-1 instance
// for streaming fetches and counter wrap.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_req, d_read, d_write;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata, i_count, d_count;
  logic        i_ready, d_ready, mem_read, mem_write;

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .i_count(i_count), .d_count(d_count)
  );

  // Memory model: one remembered write, otherwise a fixed address pattern.
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr_m = 16'h0, wr_data_m = 16'h0;
  assign mem_rdata = (wr_valid && mem_addr == wr_addr_m) ? wr_data_m : (mem_addr ^ 16'hA133);
  always @(posedge clk) begin
    if (mem_write) begin
      wr_valid  <= 1'b1;
      wr_addr_m <= mem_addr;
      wr_data_m <= mem_wdata;
    end
  end

  // Narrow instance: 8-bit words, single-cycle latency.
  logic       n_i_req, n_d_read, n_d_write;
  logic [7:0] n_i_addr, n_d_addr, n_d_wdata;
  logic [7:0] n_i_data, n_d_rdata, n_mem_addr, n_mem_wdata, n_mem_rdata, n_i_count, n_d_count;
  logic       n_i_ready, n_d_ready, n_mem_read, n_mem_write;

  mem_port_arbiter #(.WORD_SIZE(8), .MEM_LATENCY(1)) u_narrow (
    .clk(clk), .reset_n(reset_n),
    .i_req(n_i_req), .i_addr(n_i_addr), .i_data(n_i_data), .i_ready(n_i_ready),
    .d_read(n_d_read), .d_write(n_d_write), .d_addr(n_d_addr), .d_wdata(n_d_wdata),
    .d_rdata(n_d_rdata), .d_ready(n_d_ready),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata),
    .i_count(n_i_count), .d_count(n_d_count)
  );
  assign n_mem_rdata = n_mem_addr ^ 8'h5A;

  typedef struct packed {
    logic        is_d;
    logic        chk;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until the access chain drains; pops the scoreboard on each ready.
  task automatic service(input int max_cyc, input int drop_i_at, input int drop_d_at,
                         output int rd_cyc, output int wr_cyc, output int gaps,
                         output int first_rdy, output logic [15:0] w_addr,
                         output logic [15:0] w_data);
    exp_t e;
    logic done;
    rd_cyc = 0; wr_cyc = 0; gaps = 0; first_rdy = -1; w_addr = '0; w_data = '0; done = 1'b0;
    for (int cyc = 1; cyc <= max_cyc && !done; cyc++) begin
      @(negedge clk);
      if (cyc == drop_i_at) i_req = 1'b0;
      if (cyc == drop_d_at) begin d_read = 1'b0; d_write = 1'b0; end
      if (mem_read && mem_write) check("rd_wr_exclusive", 32'(mem_write), 32'd0);
      if (i_ready && d_ready) check("ready_exclusive", 32'(d_ready), 32'd0);
      if (mem_read) rd_cyc++;
      if (mem_write) begin wr_cyc++; w_addr = mem_addr; w_data = mem_wdata; end
      if (!mem_read && !mem_write && sb.size() != 0) gaps++;
      if (i_ready || d_ready) begin
        if (first_rdy < 0) first_rdy = cyc;
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(d_ready), 32'(i_ready));
        end else begin
          e = sb.pop_front();
          check("ready_port", 32'(d_ready), 32'(e.is_d));
          if (e.chk) check("read_data", 32'(e.is_d ? d_rdata : i_data), 32'(e.data));
        end
      end
      if (!mem_read && !mem_write && sb.size() == 0) done = 1'b1;
    end
    check("service_done", 32'(done), 32'd1);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, wr, gaps, first, pulses;
    logic [15:0] wa, wd;
    logic [7:0] exp_cnt;

    reset_n = 1'b0; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    n_i_req = 1'b0; n_d_read = 1'b0; n_d_write = 1'b0;
    n_i_addr = '0; n_d_addr = '0; n_d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_i_data", 32'(i_data), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_i_count", 32'(i_count), 32'd0);
    check("rst_d_count", 32'(d_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_cmd", 32'(mem_read | mem_write), 32'd0);

    // Single fetch; request dropped after grant
    i_req = 1'b1; i_addr = 16'h0010;
    sb.push_back('{is_d: 1'b0, chk: 1'b1, data: 16'hA123});
    service(20, 1, 0, rd, wr, gaps, first, wa, wd);
    check("fetch_rd_cycles", 32'(rd), 32'd2);
    check("fetch_wr_cycles", 32'(wr), 32'd0);
    check("fetch_latency", 32'(first), 32'd2);
    check("fetch_i_count", 32'(i_count), 32'd1);
    check("fetch_i_data_held", 32'(i_data), 32'hA123);
    check("fetch_d_count", 32'(d_count), 32'd0);

    // Store
    d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
    sb.push_back('{is_d: 1'b1, chk: 1'b0, data: 16'h0});
    service(20, 0, 1, rd, wr, gaps, first, wa, wd);
    check("store_wr_cycles", 32'(wr), 32'd2);
    check("store_rd_cycles", 32'(rd), 32'd0);
    check("store_addr", 32'(wa), 32'h0040);
    check("store_wdata", 32'(wd), 32'h5555);
    check("store_latency", 32'(first), 32'd2);
    check("store_d_count", 32'(d_count), 32'd1);

    // Load back the stored word
    d_read = 1'b1; d_addr = 16'h0040;
    sb.push_back('{is_d: 1'b1, chk: 1'b1, data: 16'h5555});
    service(20, 0, 1, rd, wr, gaps, first, wa, wd);
    check("load_rd_cycles", 32'(rd), 32'd2);
    check("load_d_rdata_held", 32'(d_rdata), 32'h5555);
    check("load_d_count", 32'(d_count), 32'd2);

    // Read and write both high is a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0041; d_wdata = 16'h1234;
    sb.push_back('{is_d: 1'b1, chk: 1'b0, data: 16'h0});
    service(20, 0, 1, rd, wr, gaps, first, wa, wd);
    check("rdwr_wr_cycles", 32'(wr), 32'd2);
    check("rdwr_rd_cycles", 32'(rd), 32'd0);
    check("rdwr_wdata", 32'(wd), 32'h1234);

    // Simultaneous fetch and load: data first, fetch follows with no bubble
    i_req = 1'b1; i_addr = 16'h0010; d_read = 1'b1; d_addr = 16'h0041;
    sb.push_back('{is_d: 1'b1, chk: 1'b1, data: 16'h1234});
    sb.push_back('{is_d: 1'b0, chk: 1'b1, data: 16'hA123});
    service(20, 3, 1, rd, wr, gaps, first, wa, wd);
    check("b2b_gaps", 32'(gaps), 32'd0);
    check("b2b_rd_cycles", 32'(rd), 32'd4);
    check("b2b_first_ready", 32'(first), 32'd2);
    check("b2b_i_count", 32'(i_count), 32'd2);
    check("b2b_d_count", 32'(d_count), 32'd4);

    // Reset in the middle of a load
    d_read = 1'b1; d_addr = 16'h0010;
    @(posedge clk);
    #2;
    d_read = 1'b0;
    check("pre_rst_busy", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_mem_read", 32'(mem_read), 32'd0);
    check("async_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("async_rst_d_ready", 32'(d_ready), 32'd0);
    check("async_rst_i_count", 32'(i_count), 32'd0);
    check("async_rst_d_count", 32'(d_count), 32'd0);
    check("async_rst_i_data", 32'(i_data), 32'd0);
    check("async_rst_d_rdata", 32'(d_rdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_ready || i_ready || mem_read || mem_write) pulses++;
    end
    check("post_rst_quiet", 32'(pulses), 32'd0);
    check("post_rst_d_count", 32'(d_count), 32'd0);

    // Normal fetch after reset
    i_req = 1'b1; i_addr = 16'h0010;
    sb.push_back('{is_d: 1'b0, chk: 1'b1, data: 16'hA123});
    service(20, 1, 0, rd, wr, gaps, first, wa, wd);
    check("post_rst_fetch_latency", 32'(first), 32'd2);
    check("post_rst_i_count", 32'(i_count), 32'd1);
    check("post_rst_rd_cycles", 32'(rd), 32'd2);

    // Latency 1, continuous fetch: ready every cycle
    n_i_req = 1'b1; n_i_addr = 8'h03;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stream_i_ready", 32'(n_i_ready), 32'd1);
      check("stream_i_data", 32'(n_i_data), 32'h59);
    end
    n_i_req = 1'b0;
    @(negedge clk);
    check("stream_i_count", 32'(n_i_count), 32'd6);
    check("stream_stop_ready", 32'(n_i_ready), 32'd0);

    // Completion counter wraps from all-ones to zero
    n_d_read = 1'b1; n_d_addr = 8'h07;
    exp_cnt = 8'h00; pulses = 0;
    for (int c = 0; c < 400 && pulses < 257; c++) begin
      @(negedge clk);
      check("wrap_d_count", 32'(n_d_count), 32'(exp_cnt));
      if (n_d_ready) begin
        pulses++;
        exp_cnt = exp_cnt + 8'd1;
      end
    end
    n_d_read = 1'b0;
    @(negedge clk);
    check("wrap_pulses", 32'(pulses), 32'd257);
    check("wrap_final_count", 32'(n_d_count), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
